uart_rx_fifo: RTL and testbench

Receive-side byte buffer between the UART receiver and the bus/processor interface. Captures every byte the receiver presents with its one-cycle done tick, holds up to 2^ADDR_W bytes, and gives the reader a first-word-fall-through pop interface. Also reports occupancy and a sticky overrun flag.

---
 rtl/uart_rx_fifo.sv | 88 ++++++++
 tb/tb_uart_rx_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART receiver and the bus side: FWFT pop, occupancy, sticky overrun.
// Define UART_RX_FIFO_OVERWRITE_EN to drop the oldest byte instead of the newest when a write hits a full FIFO.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_tick,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd,
  input  logic              clr_overrun,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              overrun_q;

  logic pop_ok;
  logic blocked_write;
  logic wr_en;
  logic rd_en;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_COUNT);
  assign count   = count_q;
  assign overrun = overrun_q;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // A write that meets a full FIFO with no pop alongside it is the overrun case.
  assign pop_ok        = rd && !empty;
  assign blocked_write = wr_tick && full && !rd;

  always_comb begin
    wr_en = wr_tick && (!full || pop_ok);
    rd_en = pop_ok;
`ifdef UART_RX_FIFO_OVERWRITE_EN
    if (blocked_write) begin
      wr_en = 1'b1;
      rd_en = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (wr_en && !rd_en) begin
        count_q <= count_q + (ADDR_W+1)'(1);
      end else if (rd_en && !wr_en) begin
        count_q <= count_q - (ADDR_W+1)'(1);
      end
      // Set takes priority over clear so a simultaneous overrun is never lost.
      if (blocked_write) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: constant vector table, directed corner sequences,
// and randomized traffic compared against a queue-based model of the FIFO.
module tb_uart_rx_fifo;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              wr_tick = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd = 1'b0;
  logic              clr_overrun = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overrun;

  int total = 0;
  int bad = 0;

  logic [DATA_W-1:0] model_q[$];
  bit                model_ovr = 1'b0;

  uart_rx_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .reset(reset),
    .wr_tick(wr_tick),
    .wr_data(wr_data),
    .rd(rd),
    .clr_overrun(clr_overrun),
    .rd_data(rd_data),
    .empty(empty),
    .full(full),
    .count(count),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    bit         w;
    logic [7:0] d;
    bit         r;
    bit         c;
    int         cnt;
    bit         emp;
    bit         ful;
    bit         ovr;
    logic [7:0] dat;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // The model works on whole-queue semantics: occupancy is the queue length, head is q[0].
  task automatic modelUpdate(input bit r_rst, input bit w, input logic [7:0] d,
                             input bit r, input bit c);
    bit was_full;
    if (r_rst) begin
      model_q.delete();
      model_ovr = 1'b0;
      return;
    end
    was_full = (model_q.size() == DEPTH);
    if (w && was_full && !r) begin
`ifdef UART_RX_FIFO_OVERWRITE_EN
      void'(model_q.pop_front());
      model_q.push_back(d);
`endif
      model_ovr = 1'b1;
    end else begin
      if (r && model_q.size() > 0) void'(model_q.pop_front());
      if (w) model_q.push_back(d);
      if (c) model_ovr = 1'b0;
    end
  endtask

  task automatic compareModel(input string tag);
    int exp_data;
    exp_data = (model_q.size() > 0) ? int'(model_q[0]) : 0;
    checkOutput({tag, ".count"}, int'(count), model_q.size());
    checkOutput({tag, ".empty"}, int'(empty), int'(model_q.size() == 0));
    checkOutput({tag, ".full"}, int'(full), int'(model_q.size() == DEPTH));
    checkOutput({tag, ".overrun"}, int'(overrun), int'(model_ovr));
    checkOutput({tag, ".rd_data"}, int'(rd_data), exp_data);
  endtask

  task automatic applyStimulus(input bit r_rst, input bit w, input logic [7:0] d,
                               input bit r, input bit c, input string tag);
    reset = r_rst;
    wr_tick = w;
    wr_data = d;
    rd = r;
    clr_overrun = c;
    @(posedge clk);
    modelUpdate(r_rst, w, d, r, c);
    #1;
    compareModel(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, tag);
  endtask

  task automatic fillSeq(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 8'(i), 1'b0, 1'b0, tag);
  endtask

  task automatic popExpect(input logic [7:0] exp, input string tag);
    checkOutput({tag, ".head"}, int'(rd_data), int'(exp));
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, tag);
  endtask

  initial begin
    vecs[0] = '{1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00};
    vecs[1] = '{0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00};
    vecs[2] = '{0, 0, 8'h00, 1, 0, 0, 1, 0, 0, 8'h00};
    vecs[3] = '{0, 1, 8'h55, 0, 0, 1, 0, 0, 0, 8'h55};
    vecs[4] = '{0, 0, 8'h00, 1, 0, 0, 1, 0, 0, 8'h00};
    vecs[5] = '{0, 1, 8'hA1, 1, 0, 1, 0, 0, 0, 8'hA1};
    vecs[6] = '{0, 1, 8'hB2, 1, 0, 1, 0, 0, 0, 8'hB2};
    vecs[7] = '{0, 0, 8'h00, 1, 0, 0, 1, 0, 0, 8'h00};
    vecs[8] = '{0, 0, 8'h00, 0, 1, 0, 1, 0, 0, 8'h00};

    #2;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].w, vecs[i].d, vecs[i].r, vecs[i].c, $sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d.count_tbl", i), int'(count), vecs[i].cnt);
      checkOutput($sformatf("vec%0d.empty_tbl", i), int'(empty), int'(vecs[i].emp));
      checkOutput($sformatf("vec%0d.full_tbl", i), int'(full), int'(vecs[i].ful));
      checkOutput($sformatf("vec%0d.ovr_tbl", i), int'(overrun), int'(vecs[i].ovr));
      checkOutput($sformatf("vec%0d.data_tbl", i), int'(rd_data), int'(vecs[i].dat));
    end

    // Fill, partially drain, refill across the wrap point, then drain in order.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "wrap.rst");
    fillSeq(16, "wrap.fill");
    checkOutput("wrap.full", int'(full), 1);
    checkOutput("wrap.count16", int'(count), 16);
    for (int i = 0; i < 8; i++) popExpect(8'(i), "wrap.pop");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, "wrap.refill");
    for (int i = 0; i < 16; i++) popExpect(8'(8'h08 + i), "wrap.drain");
    checkOutput("wrap.empty", int'(empty), 1);

    // Overrun on a full FIFO, then drain.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "ovr.rst");
    fillSeq(16, "ovr.fill");
    applyStimulus(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, "ovr.hit");
    checkOutput("ovr.flag", int'(overrun), 1);
    checkOutput("ovr.count", int'(count), 16);
`ifdef UART_RX_FIFO_OVERWRITE_EN
    for (int i = 1; i < 16; i++) popExpect(8'(i), "ovr.drain");
    popExpect(8'hAA, "ovr.drain_last");
`else
    for (int i = 0; i < 16; i++) popExpect(8'(i), "ovr.drain");
`endif
    checkOutput("ovr.sticky", int'(overrun), 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "ovr.clr");
    checkOutput("ovr.cleared", int'(overrun), 0);

    // Simultaneous write+read while full, then overrun set colliding with clear.
    fillSeq(16, "sim.fill");
    applyStimulus(1'b0, 1'b1, 8'h77, 1'b1, 1'b0, "sim.wr_rd_full");
    checkOutput("sim.count16", int'(count), 16);
    checkOutput("sim.no_ovr", int'(overrun), 0);
    checkOutput("sim.head", int'(rd_data), 1);
    applyStimulus(1'b0, 1'b1, 8'h99, 1'b0, 1'b1, "sim.set_clr");
    checkOutput("sim.set_wins", int'(overrun), 1);

    // Reset mid-stream discards everything stored.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "mid.rst0");
    fillSeq(5, "mid.fill");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "mid.rst");
    checkOutput("mid.count0", int'(count), 0);
    checkOutput("mid.empty", int'(empty), 1);
    checkOutput("mid.ovr0", int'(overrun), 0);
    applyStimulus(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, "mid.wr");
    popExpect(8'h3C, "mid.pop");
    checkOutput("mid.empty_after", int'(empty), 1);
    checkOutput("mid.data0", int'(rd_data), 0);

    // Random traffic in phases biased toward filling and toward draining.
    for (int p = 0; p < 12; p++) begin
      int wprob;
      int rprob;
      wprob = (p % 2 == 0) ? 85 : 30;
      rprob = (p % 2 == 0) ? 25 : 80;
      for (int i = 0; i < 150; i++) begin
        bit rr;
        rr = ($urandom_range(0, 499) == 0);
        applyStimulus(rr, ($urandom_range(0, 99) < wprob), 8'($urandom),
                      ($urandom_range(0, 99) < rprob), ($urandom_range(0, 99) < 5), "rand");
      end
    end

    idle("end");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
